// File: rtl/instruction_fetch_if.sv
// Instruction-fetch bus: pipeline control in, program-memory read port and
// IF/ID-facing outputs. master = fetch unit, slave = pipeline/memory side.
interface instruction_fetch_if #(
  parameter int unsigned ADDR_WIDTH = 14
);
  logic                  stall;
  logic                  redirect;
  logic [ADDR_WIDTH-1:0] redirect_addr;
  logic                  halt;
  logic [ADDR_WIDTH-1:0] pmem_addr;
  logic [31:0]           pmem_data;
  logic [31:0]           instruction_out;
  logic [ADDR_WIDTH-1:0] return_addr_out;
  logic                  fetch_valid;
  logic                  halted;

  modport master (
    input  stall, redirect, redirect_addr, halt, pmem_data,
    output pmem_addr, instruction_out, return_addr_out, fetch_valid, halted
  );

  modport slave (
    output stall, redirect, redirect_addr, halt, pmem_data,
    input  pmem_addr, instruction_out, return_addr_out, fetch_valid, halted
  );
endinterface

// File: rtl/instruction_fetch.sv
// Instruction fetch stage: owns the PC, drives the synchronous program-memory
// read port and presents instruction/return address to the IF/ID register.
//
// state     | meaning
// ----------+----------------------------------------------------------
// ST_BOOT   | first cycle after reset, fetching RESET_VECTOR
// ST_RUN    | fetching sequentially, honouring stall and redirect
// ST_HALTED | decode saw HALT; emit NOP until a redirect arrives
module instruction_fetch #(
  parameter int unsigned             ADDR_WIDTH   = 14,
  parameter logic [ADDR_WIDTH-1:0]   RESET_VECTOR = '0,
  parameter logic [31:0]             NOP_WORD     = 32'h0000_0000
) (
  input logic                clock,
  input logic                nreset,
  instruction_fetch_if.master bus
);

  typedef enum logic [1:0] {
    ST_BOOT   = 2'd0,
    ST_RUN    = 2'd1,
    ST_HALTED = 2'd2
  } state_t;

  state_t                fsm;
  logic [ADDR_WIDTH-1:0] pc;
  logic [ADDR_WIDTH-1:0] if_addr;
  logic                  if_valid;
  logic                  halted_q;
  logic                  fetch_ok;

  // Re-reading if_addr while stalled keeps pmem_data stable for the held word.
  always_comb begin
    bus.pmem_addr = pc;
    if (bus.redirect)
      bus.pmem_addr = bus.redirect_addr;
    else if (bus.stall && if_valid)
      bus.pmem_addr = if_addr;
  end

  assign fetch_ok            = if_valid & ~bus.redirect;
  assign bus.instruction_out = fetch_ok ? bus.pmem_data : NOP_WORD;
  assign bus.fetch_valid     = fetch_ok;
  assign bus.return_addr_out = if_addr + 1'b1;
  assign bus.halted          = halted_q;

  always_ff @(posedge clock or negedge nreset) begin
    if (!nreset) begin
      fsm      <= ST_BOOT;
      pc       <= RESET_VECTOR;
      if_addr  <= '0;
      if_valid <= 1'b0;
      halted_q <= 1'b0;
    end else if (bus.redirect) begin
      pc       <= bus.redirect_addr + 1'b1;
      if_addr  <= bus.redirect_addr;
      if_valid <= 1'b1;
      fsm      <= ST_RUN;
      halted_q <= 1'b0;
    end else begin
      case (fsm)
        ST_BOOT: begin
          pc       <= pc + 1'b1;
          if_addr  <= pc;
          if_valid <= 1'b1;
          fsm      <= ST_RUN;
        end
        ST_RUN: begin
          if (bus.halt) begin
            if_valid <= 1'b0;
            fsm      <= ST_HALTED;
            halted_q <= 1'b1;
          end else if (!bus.stall) begin
            pc       <= pc + 1'b1;
            if_addr  <= pc;
            if_valid <= 1'b1;
          end
        end
        ST_HALTED: begin
          if_valid <= 1'b0;
          halted_q <= 1'b1;
        end
        default: begin
          fsm      <= ST_BOOT;
          if_valid <= 1'b0;
          halted_q <= 1'b0;
        end
      endcase
    end
  end

endmodule
